// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake into a
// small prefetch FIFO, and presents instructions to the decoder through IF/ID.
module if_stage #(
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              CLK,
    input  logic              RST_N,
    output logic              IMEM_REQ,
    output logic [ADDR_W-1:0] IMEM_ADDR,
    input  logic              IMEM_ACK,
    input  logic [15:0]       IMEM_RDATA,
    input  logic              STALL,
    input  logic              REDIRECT,
    input  logic [ADDR_W-1:0] REDIRECT_PC,
    input  logic              WRONG_OP_CODE,
    output logic              ID_VALID,
    output logic [15:0]       ID_INSTR,
    output logic [ADDR_W-1:0] ID_PC,
    output logic [3:0]        OP_CODE,
    output logic [3:0]        FUNC_CODE,
    output logic              TRAP,
    output logic [ADDR_W-1:0] TRAP_PC
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic {
        RUN,
        HALTED
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] pc;
    logic [15:0]       fifo_instr [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_pc    [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;

    logic fifo_empty;
    logic fire;
    logic trap_hit;
    logic flush;
    logic push;
    logic pop;

    // Redirect outranks the illegal-opcode halt; either one flushes everything in flight.
    assign fifo_empty = (count == '0);
    assign fire       = IMEM_REQ && IMEM_ACK;
    assign trap_hit   = ID_VALID && WRONG_OP_CODE && !REDIRECT;
    assign flush      = REDIRECT || trap_hit;
    assign push       = fire && !flush;
    assign pop        = !flush && !STALL && !fifo_empty;

    assign IMEM_REQ  = RST_N && (state == RUN) && (count < FULL_CNT);
    assign IMEM_ADDR = pc;
    assign TRAP      = (state == HALTED);
    assign OP_CODE   = ID_INSTR[15:12];
    assign FUNC_CODE = ID_INSTR[3:0];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (REDIRECT) begin
            state_next = RUN;
        end else if (trap_hit) begin
            state_next = HALTED;
        end
    end

    // PC freezes on a halt; an ack in a flush cycle never advances it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pc <= RESET_PC;
        end else if (REDIRECT) begin
            pc <= REDIRECT_PC;
        end else if (push) begin
            pc <= pc + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage needs no reset: the count alone decides which slots are live.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_instr[wr_ptr] <= IMEM_RDATA;
            fifo_pc[wr_ptr]    <= pc;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ID_VALID <= 1'b0;
            ID_INSTR <= '0;
            ID_PC    <= '0;
        end else if (flush) begin
            ID_VALID <= 1'b0;
        end else if (!STALL) begin
            if (!fifo_empty) begin
                ID_VALID <= 1'b1;
                ID_INSTR <= fifo_instr[rd_ptr];
                ID_PC    <= fifo_pc[rd_ptr];
            end else begin
                ID_VALID <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            TRAP_PC <= '0;
        end else if (trap_hit) begin
            TRAP_PC <= ID_PC;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios followed by random traffic,
// all compared every cycle against a queue-based model of the fetch stage.
module tb_if_stage;

    localparam logic [15:0] RST_PC = 16'h0010;
    localparam int          DEPTH  = 2;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        wrong_op_code;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [15:0] id_pc;
    logic [3:0]  op_code;
    logic [3:0]  func_code;
    logic        trap;
    logic [15:0] trap_pc;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } entry_t;

    entry_t      m_fifo[$];
    logic [15:0] m_pc;
    logic        m_valid;
    logic [15:0] m_instr;
    logic [15:0] m_id_pc;
    logic        m_halted;
    logic [15:0] m_trap_pc;

    if_stage #(
        .ADDR_W(16),
        .RESET_PC(RST_PC),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .CLK(clk),
        .RST_N(rst_n),
        .IMEM_REQ(imem_req),
        .IMEM_ADDR(imem_addr),
        .IMEM_ACK(imem_ack),
        .IMEM_RDATA(imem_rdata),
        .STALL(stall),
        .REDIRECT(redirect),
        .REDIRECT_PC(redirect_pc),
        .WRONG_OP_CODE(wrong_op_code),
        .ID_VALID(id_valid),
        .ID_INSTR(id_instr),
        .ID_PC(id_pc),
        .OP_CODE(op_code),
        .FUNC_CODE(func_code),
        .TRAP(trap),
        .TRAP_PC(trap_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] imem_word(input logic [15:0] addr);
        logic [15:0] w;
        case (addr)
            16'h0010: w = 16'h1203;
            16'h0011: w = 16'h2304;
            16'h0012: w = 16'h3405;
            default:  w = (addr ^ {addr[7:0], addr[15:8]}) + 16'h1357;
        endcase
        return w;
    endfunction

    assign imem_rdata = imem_word(imem_addr);

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_fifo.delete();
        m_pc      = RST_PC;
        m_valid   = 1'b0;
        m_instr   = '0;
        m_id_pc   = '0;
        m_halted  = 1'b0;
        m_trap_pc = '0;
    endtask

    task automatic checkOutput();
        logic req_exp;
        req_exp = rst_n && !m_halted && (m_fifo.size() < DEPTH);
        check("imem_req",  32'(imem_req),  32'(req_exp));
        check("imem_addr", 32'(imem_addr), 32'(m_pc));
        check("id_valid",  32'(id_valid),  32'(m_valid));
        check("id_instr",  32'(id_instr),  32'(m_instr));
        check("id_pc",     32'(id_pc),     32'(m_id_pc));
        check("op_code",   32'(op_code),   32'(m_instr[15:12]));
        check("func_code", 32'(func_code), 32'(m_instr[3:0]));
        check("trap",      32'(trap),      32'(m_halted));
        check("trap_pc",   32'(trap_pc),   32'(m_trap_pc));
    endtask

    // One clock: drive inputs, let the model consume the edge, compare at the falling edge.
    task automatic applyStimulus(input logic s, input logic a, input logic r,
                                 input logic [15:0] rpc, input logic w);
        logic   fire;
        entry_t head;
        stall         = s;
        imem_ack      = a;
        redirect      = r;
        redirect_pc   = rpc;
        wrong_op_code = w;
        fire = !m_halted && (m_fifo.size() < DEPTH) && a;
        @(posedge clk);
        if (r) begin
            m_fifo.delete();
            m_pc     = rpc;
            m_valid  = 1'b0;
            m_halted = 1'b0;
        end else if (m_valid && w) begin
            m_fifo.delete();
            m_halted  = 1'b1;
            m_trap_pc = m_id_pc;
            m_valid   = 1'b0;
        end else begin
            if (!s) begin
                if (m_fifo.size() > 0) begin
                    head    = m_fifo.pop_front();
                    m_instr = head.instr;
                    m_id_pc = head.pc;
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
            end
            if (fire) begin
                m_fifo.push_back({m_pc, imem_word(m_pc)});
                m_pc = m_pc + 16'd1;
            end
        end
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        rst_n         = 1'b0;
        stall         = 1'b0;
        imem_ack      = 1'b0;
        redirect      = 1'b0;
        redirect_pc   = '0;
        wrong_op_code = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput();
        rst_n = 1'b1;
        #1;
        check("req_after_reset", 32'(imem_req), 32'd1);
        check("addr_after_reset", 32'(imem_addr), 32'h0010);

        // Stream from RESET_PC with ack held high
        applyStimulus(0, 1, 0, 16'h0, 0);
        check("addr_step1", 32'(imem_addr), 32'h0011);
        check("valid_before_latency", 32'(id_valid), 32'd0);
        applyStimulus(0, 1, 0, 16'h0, 0);
        check("first_instr", 32'(id_instr), 32'h1203);
        check("first_opcode", 32'(op_code), 32'h1);
        check("first_func", 32'(func_code), 32'h3);
        applyStimulus(0, 1, 0, 16'h0, 0);
        check("second_instr", 32'(id_instr), 32'h2304);
        applyStimulus(0, 1, 0, 16'h0, 0);
        check("third_instr", 32'(id_instr), 32'h3405);

        // Stall: FIFO fills, request drops, IF/ID holds
        repeat (4) applyStimulus(1, 1, 0, 16'h0, 0);
        check("stall_req_low", 32'(imem_req), 32'd0);
        check("stall_pc_frozen", 32'(imem_addr), 32'h0015);
        check("stall_id_hold", 32'(id_pc), 32'h0012);
        applyStimulus(0, 1, 0, 16'h0, 0);
        check("release_first", 32'(id_pc), 32'h0013);
        applyStimulus(0, 1, 0, 16'h0, 0);
        check("release_second", 32'(id_pc), 32'h0014);

        // Ack withheld: address stable, IF/ID drains
        repeat (3) applyStimulus(0, 0, 0, 16'h0, 0);
        check("noack_addr", 32'(imem_addr), 32'h0016);
        check("noack_drained", 32'(id_valid), 32'd0);
        repeat (2) applyStimulus(0, 1, 0, 16'h0, 0);
        check("ack_resume", 32'(id_pc), 32'h0016);

        // Redirect with a full FIFO
        applyStimulus(1, 1, 0, 16'h0, 0);
        applyStimulus(0, 1, 1, 16'h0040, 0);
        check("redir_addr", 32'(imem_addr), 32'h0040);
        check("redir_valid", 32'(id_valid), 32'd0);
        repeat (2) applyStimulus(0, 1, 0, 16'h0, 0);
        check("redir_first_pc", 32'(id_pc), 32'h0040);

        // Illegal opcode halts the stage until a redirect
        applyStimulus(0, 1, 1, 16'h0013, 0);
        repeat (2) applyStimulus(0, 1, 0, 16'h0, 0);
        check("pre_trap_pc", 32'(id_pc), 32'h0013);
        applyStimulus(0, 1, 0, 16'h0, 1);
        check("trap_set", 32'(trap), 32'd1);
        check("trap_pc", 32'(trap_pc), 32'h0013);
        check("trap_req", 32'(imem_req), 32'd0);
        check("trap_valid", 32'(id_valid), 32'd0);
        repeat (2) applyStimulus(0, 1, 0, 16'h0, 1);
        applyStimulus(0, 1, 1, 16'h0000, 0);
        check("trap_cleared", 32'(trap), 32'd0);
        check("resume_addr", 32'(imem_addr), 32'h0000);

        // PC wrap
        applyStimulus(0, 1, 1, 16'hFFFF, 0);
        applyStimulus(0, 1, 0, 16'h0, 0);
        check("wrap_addr", 32'(imem_addr), 32'h0000);
        applyStimulus(0, 1, 0, 16'h0, 0);
        check("wrap_id_pc", 32'(id_pc), 32'hFFFF);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 31) == 0), 16'($urandom_range(0, 65535)),
                          ($urandom_range(0, 15) == 0));
        end

        // Asynchronous reset between clock edges
        applyStimulus(0, 1, 0, 16'h0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput();
        @(negedge clk);
        checkOutput();
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) != 0),
                          ($urandom_range(0, 31) == 0), 16'($urandom_range(0, 65535)),
                          ($urandom_range(0, 15) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
